// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the pipelined MIPS front end: the
//               next-PC select codes, the reset/bubble defaults and the
//               instruction field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int unsigned IMM16_W = 16;
   localparam int unsigned INDEX_W = 26;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Branch displacement in bytes: sign-extended word offset shifted by two.
   function automatic logic [31:0] branch_offset(input logic [IMM16_W-1:0] imm);
      return {{(32 - IMM16_W - 2){imm[IMM16_W-1]}}, imm, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC selection (sequential, branch, jump,
//               jump-register). Redirects are ignored while ID holds a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [31:0]        if_pc,
   input  logic [31:0]        id_pc,
   input  logic               id_valid,
   input  logic [1:0]         npc_sel,
   input  logic [IMM16_W-1:0] br_imm16,
   input  logic [INDEX_W-1:0] jump_index,
   input  logic [31:0]        jr_target,
   output logic [31:0]        npc
);

   logic [31:0] id_pc_plus_4;
   logic [1:0]  sel_eff;

   always_comb begin
      id_pc_plus_4 = id_pc + 32'd4;
      sel_eff      = id_valid ? npc_sel : NPC_PC4;
      npc          = if_pc + 32'd4;
      unique case (sel_eff)
         NPC_PC4: npc = if_pc + 32'd4;
         NPC_BR:  npc = id_pc_plus_4 + branch_offset(br_imm16);
         // Jump region comes from the delay-slot address, not the jump itself.
         NPC_J:   npc = {id_pc_plus_4[31:28], jump_index, 2'b00};
         NPC_JR:  npc = jr_target;
         default: npc = if_pc + 32'd4;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC register, next-PC selection and the
//               IF/ID register. Define FETCH_STAT_EN for fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic [1:0]         npc_sel,
   input  logic [IMM16_W-1:0] br_imm16,
   input  logic [INDEX_W-1:0] jump_index,
   input  logic [31:0]        jr_target,
   output logic [31:0]        im_addr,
   input  logic [31:0]        im_rdata,
   output logic [31:0]        if_pc,
   output logic [31:0]        id_instr,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_pc_plus_8,
`ifdef FETCH_STAT_EN
   output logic [31:0]        stat_fetched,
   output logic [31:0]        stat_stalls,
`endif
   output logic               id_valid
);

   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        id_valid_q, id_valid_d;
   logic        fetch_load;
   logic [31:0] npc;

   next_pc_calc u_next_pc_calc (
      .if_pc      (if_pc_q),
      .id_pc      (id_pc_q),
      .id_valid   (id_valid_q),
      .npc_sel    (npc_sel),
      .br_imm16   (br_imm16),
      .jump_index (jump_index),
      .jr_target  (jr_target),
      .npc        (npc)
   );

   // Flush owns IF/ID, stall owns the PC; both together bubble IF/ID only.
   always_comb begin
      if_pc_d    = if_pc_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      fetch_load = 1'b0;
      if (!stall) begin
         if_pc_d = npc;
      end
      if (flush) begin
         id_instr_d = NOP_WORD;
         id_pc_d    = if_pc_q;
         id_valid_d = 1'b0;
      end else if (!stall) begin
         id_instr_d = im_rdata;
         id_pc_d    = if_pc_q;
         id_valid_d = 1'b1;
         fetch_load = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_pc_q    <= RESET_PC;
         id_instr_q <= NOP_WORD;
         id_pc_q    <= 32'd0;
         id_valid_q <= 1'b0;
      end else begin
         if_pc_q    <= if_pc_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign im_addr      = if_pc_q;
   assign if_pc        = if_pc_q;
   assign id_instr     = id_instr_q;
   assign id_pc        = id_pc_q;
   assign id_pc_plus_8 = id_pc_q + 32'd8;
   assign id_valid     = id_valid_q;

`ifdef FETCH_STAT_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_stalls_q, stat_stalls_d;

   always_comb begin
      stat_fetched_d = stat_fetched_q + {31'd0, fetch_load};
      stat_stalls_d  = stat_stalls_q + {31'd0, stall};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetched_q <= 32'd0;
         stat_stalls_q  <= 32'd0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_stalls_q  <= stat_stalls_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_stalls  = stat_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage: a pipeline-level model
//               predicts each cycle's state, a monitor compares the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [1:0]  npc_sel;
   logic [15:0] br_imm16;
   logic [25:0] jump_index;
   logic [31:0] jr_target, im_rdata;
   logic [31:0] im_addr, if_pc, id_instr, id_pc, id_pc_plus_8;
   logic        id_valid;
`ifdef FETCH_STAT_EN
   logic [31:0] stat_fetched, stat_stalls;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] if_pc;
      logic [31:0] id_instr;
      logic [31:0] id_pc;
      logic        id_valid;
      logic [31:0] fetched;
      logic [31:0] stalls;
   } exp_t;

   exp_t exp_q[$];

   // Architectural model state (what the pipeline should hold after each edge)
   logic [31:0] m_pc, m_instr, m_idpc, m_fetched, m_stalls;
   logic        m_valid;

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .npc_sel      (npc_sel),
      .br_imm16     (br_imm16),
      .jump_index   (jump_index),
      .jr_target    (jr_target),
      .im_addr      (im_addr),
      .im_rdata     (im_rdata),
      .if_pc        (if_pc),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_pc_plus_8 (id_pc_plus_8),
`ifdef FETCH_STAT_EN
      .stat_fetched (stat_fetched),
      .stat_stalls  (stat_stalls),
`endif
      .id_valid     (id_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] target(input logic [1:0] sel);
      logic [31:0] delay_slot;
      delay_slot = m_idpc + 32'd4;
      case (sel)
         2'b01:   return delay_slot + 32'($signed(br_imm16) * 4);
         2'b10:   return (delay_slot & 32'hF000_0000) | (32'(jump_index) * 4);
         2'b11:   return jr_target;
         default: return m_pc + 32'd4;
      endcase
   endfunction

   // Drive one cycle of inputs, advance the model, and queue the expected state.
   task automatic step(input logic rst, input logic stl, input logic fls,
                       input logic [1:0] sel, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jr,
                       input logic [31:0] rdata);
      logic [31:0] nxt;
      exp_t e;
      @(negedge clk);
      reset = rst; stall = stl; flush = fls; npc_sel = sel;
      br_imm16 = imm; jump_index = idx; jr_target = jr; im_rdata = rdata;
      if (rst) begin
         m_pc = 32'h0000_3000; m_instr = 32'd0; m_idpc = 32'd0; m_valid = 1'b0;
         m_fetched = 32'd0; m_stalls = 32'd0;
      end else begin
         nxt = m_valid ? target(sel) : m_pc + 32'd4;
         if (fls) begin
            m_instr = 32'd0; m_idpc = m_pc; m_valid = 1'b0;
         end else if (!stl) begin
            m_instr = rdata; m_idpc = m_pc; m_valid = 1'b1; m_fetched++;
         end
         if (stl) m_stalls++;
         else     m_pc = nxt;
      end
      e.if_pc = m_pc; e.id_instr = m_instr; e.id_pc = m_idpc; e.id_valid = m_valid;
      e.fetched = m_fetched; e.stalls = m_stalls;
      exp_q.push_back(e);
   endtask

   task automatic run(input logic [31:0] rdata);
      step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0, rdata);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.if_pc);
            chk("im_addr", im_addr, e.if_pc);
            chk("id_instr", id_instr, e.id_instr);
            chk("id_pc", id_pc, e.id_pc);
            chk("id_pc_plus_8", id_pc_plus_8, e.id_pc + 32'd8);
            chk("id_valid", {31'd0, id_valid}, {31'd0, e.id_valid});
`ifdef FETCH_STAT_EN
            chk("stat_fetched", stat_fetched, e.fetched);
            chk("stat_stalls", stat_stalls, e.stalls);
`endif
         end
      end
   end

   initial begin : stimulus
      reset = 1'b1; stall = 1'b0; flush = 1'b0; npc_sel = 2'b00;
      br_imm16 = '0; jump_index = '0; jr_target = '0; im_rdata = '0;
      m_pc = '0; m_instr = '0; m_idpc = '0; m_valid = 1'b0; m_fetched = '0; m_stalls = '0;

      step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0);
      run(32'h1111_1111);
      run(32'h2222_2222);
      // Branch back by two words from id_pc=0x3004; delay slot 0x3008 still enters
      step(1'b0, 1'b0, 1'b0, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h3333_3333);
      run(32'h4444_4444);
      step(1'b0, 1'b0, 1'b0, 2'b10, 16'h0, 26'h000_0C10, 32'h0, 32'h5555_5555);
      run(32'h6666_6666);
      step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'h0000_301C, 32'h7777_7777);
      run(32'h8888_8888);
      // Redirect held across a two-cycle stall, then taken when released
      step(1'b0, 1'b1, 1'b0, 2'b10, 16'h0, 26'h123_4567, 32'h0, 32'h9999_9999);
      step(1'b0, 1'b1, 1'b0, 2'b10, 16'h0, 26'h123_4567, 32'h0, 32'hAAAA_AAAA);
      step(1'b0, 1'b0, 1'b0, 2'b10, 16'h0, 26'h123_4567, 32'h0, 32'hBBBB_BBBB);
      run(32'hCCCC_CCCC);
      step(1'b0, 1'b1, 1'b1, 2'b00, 16'h0, 26'h0, 32'h0, 32'hDDDD_DDDD);
      step(1'b0, 1'b0, 1'b1, 2'b00, 16'h0, 26'h0, 32'h0, 32'hEEEE_EEEE);
      run(32'h1234_5678);
      // Wrap at the top of the address space, misaligned jr as well
      step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0BAD_0001);
      run(32'h0BAD_0002);
      run(32'h0BAD_0003);
      run(32'h0BAD_0004);
      step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'h0000_4003, 32'h0BAD_0005);
      run(32'h0BAD_0006);
      // Reset arriving during a stalled redirect
      step(1'b0, 1'b1, 1'b0, 2'b01, 16'h7FFF, 26'h0, 32'h0, 32'h0BAD_0007);
      step(1'b1, 1'b1, 1'b0, 2'b01, 16'h7FFF, 26'h0, 32'h0, 32'h0BAD_0008);
      // Five fetches and two stalls from a clean reset
      run(32'h0000_0001); run(32'h0000_0002);
      step(1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0);
      run(32'h0000_0003);
      step(1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0);
      run(32'h0000_0004); run(32'h0000_0005);
      step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(63) == 0), ($urandom_range(3) == 0),
              ($urandom_range(5) == 0), 2'($urandom_range(3)),
              16'($urandom), 26'($urandom), $urandom, $urandom);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core that replaces the single-cycle datapath. It sits directly upstream of decode.
- Owns the PC register and next-PC selection (PC+4, beq-style branch, j/jal, jr), drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register.
- Honours stall and flush from the hazard unit.
- Branch/jump resolution happens in ID with one architectural delay slot, so a redirect does not flush IF/ID.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID on reset or flush (sll $0,$0,0).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard unit: hold PC and IF/ID this cycle
flush  in  1  hazard unit: load bubble into IF/ID this cycle
npc_sel  in  2  redirect select from ID: 00 PC+4, 01 branch taken, 10 j/jal, 11 jr
br_imm16  in  16  branch offset field of the instruction in ID
jump_index  in  26  instr_index field of the instruction in ID
jr_target  in  32  forwarded rs value for jr
im_addr  out  32  instruction-memory byte address (= if_pc)
im_rdata  in  32  instruction word, combinational read of im_addr
if_pc  out  32  current PC
id_instr  out  32  IF/ID instruction
id_pc  out  32  IF/ID PC
id_pc_plus_8  out  32  id_pc+8, link value for jal
id_valid  out  1  IF/ID holds a real fetched instruction

Behaviour:
- Reset (sync, priority over all): if_pc=RESET_PC; id_instr=NOP_WORD; id_pc=0; id_valid=0; id_pc_plus_8=8 (combinational from id_pc).
- im_addr = if_pc combinationally. Fetch latency is 0 cycles to im_rdata and 1 cycle to id_instr.
- Next-PC computation (combinational, all arithmetic mod 2^32, wrap silently):
  - 00: if_pc+4
  - 01: id_pc+4+(sign_ext(br_imm16)<<2)
  - 10: {id_pc[31:28]+carry-free of (id_pc+4)[31:28], jump_index, 2'b00}, i.e. {(id_pc+4)[31:28], jump_index, 00}
  - 11: jr_target
  - npc_sel is only meaningful while id_valid=1. If id_valid=0, treat it as 00.
- Normal cycle (no stall, no flush): if_pc<=npc; id_instr<=im_rdata; id_pc<=if_pc; id_valid<=1.
- Delay slot: a redirect is applied in the same cycle the branch sits in ID. The delay-slot instruction (currently in IF) therefore enters IF/ID normally, and the target is fetched next.
- stall=1, flush=0: if_pc, id_instr, id_pc and id_valid all hold. npc_sel is ignored; the held ID instruction re-presents it next cycle.
- flush=1, stall=0: if_pc<=npc; id_instr<=NOP_WORD; id_pc<=if_pc; id_valid<=0.
- stall=1 and flush=1: PC holds; IF/ID loads the bubble (id_instr=NOP_WORD, id_valid=0). Flush wins for IF/ID; stall wins for PC.
- Reset asserted mid-stall or mid-redirect: reset values next edge, no residue.
- Misaligned jr_target is not trapped here; the low two bits pass through to im_addr unchanged.

Optional Feature:
- Macro FETCH_STAT_EN.
- Defined:
  - adds outputs stat_fetched[31:0] and stat_stalls[31:0], both reset to 0, wrapping at 2^32.
  - stat_fetched increments on every cycle where IF/ID loads with id_valid<=1.
  - stat_stalls increments on every cycle with stall=1 and reset=0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - NPC_PC4=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11
  - RESET_PC and NOP_WORD defaults
  - field widths (IMM16_W=16, INDEX_W=26)
- One combinational sub-module, next_pc_calc, computes npc from if_pc, id_pc, id_valid, npc_sel, br_imm16, jump_index and jr_target.
- The PC register, IF/ID register and optional counters live in fetch_stage.

Test Plan:
- Reset then 3 free-running cycles with im returning 0x11111111, 0x22222222, 0x33333333 -> if_pc sequence 0x3000, 0x3004, 0x3008, 0x300C; id_instr/id_pc = 0x11111111/0x3000, then 0x22222222/0x3004; id_pc_plus_8=0x3008 for the first.
- Branch: id_pc=0x3004, npc_sel=01, br_imm16=0xFFFE -> delay slot at 0x3008 enters IF/ID; next if_pc=0x3004+4-8=0x3000.
- j: id_pc=0x3010, jump_index=0x0000C10 -> next if_pc=0x00003040. jr with jr_target=0x0000301C -> next if_pc=0x301C.
- stall held 2 cycles at if_pc=0x300C with npc_sel=10 -> PC and IF/ID unchanged for both cycles; redirect takes effect on the first unstalled cycle.
- stall=1 and flush=1 together -> if_pc holds; id_instr=0, id_valid=0. Flush alone -> if_pc advances; id_valid=0.
- if_pc=0xFFFF_FFFC with npc_sel=00 -> next if_pc=0x0000_0000. With FETCH_STAT_EN, after 5 fetches and 2 stalls -> stat_fetched=5, stat_stalls=2; reset -> both 0.
